vga_fb_arbiter: RTL and testbench

- Shares one single-port framebuffer RAM between the VGA display path and a CPU write port.
- Uses the VGA timing counters (hcount/vcount) to prefetch pixels into a small FIFO ahead of the beam.
- Streams one RGB pixel per clock to the VGA controller's final_pixel inputs during the active region.
- Grants CPU writes only in cycles where the display prefetch does not need the RAM.

---
 rtl/vga_fb_arbiter_if.sv | 15 +
 rtl/vga_fb_arbiter.sv | 152 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// CPU write port of the framebuffer arbiter.
// The CPU drives a request and the arbiter answers with a same-cycle ready.
`timescale 1ns/1ps

interface vga_fb_arbiter_if #(
   parameter int ADDR_W = 19
);
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              wr_ready;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: prefetches display pixels from a single-port RAM into
// a small FIFO ahead of the beam, streams them to the VGA controller, and
// hands otherwise idle RAM cycles to the CPU write port.
`timescale 1ns/1ps

module vga_fb_arbiter #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int V_TOTAL    = 525,
   parameter int ADDR_W     = 19,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   vga_fb_arbiter_if.slave   cpu,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [23:0]       mem_wdata,
   input  logic [23:0]       mem_rdata,
   output logic [7:0]        final_pixel_r,
   output logic [7:0]        final_pixel_g,
   output logic [7:0]        final_pixel_b,
   output logic              underflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [9:0]        H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0]        V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

   typedef enum logic {F_IDLE, F_RUN} fetch_state_t;

   fetch_state_t      state, state_nxt;
   logic              frame_start, in_active;
   logic              fetch_go, wr_ready, wr_fire, wr_in_range;
   logic              inflight, push, pop, pop_ok;
   logic              port_live;
   logic [ADDR_W-1:0] fetch_addr;
   logic [CNT_W-1:0]  count, occupancy;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [23:0]       fifo_mem [FIFO_DEPTH];
   logic [23:0]       pix_p1;

   // Frame start is one full line before the first active pixel, which is
   // the prefetch head start. It never coincides with an active cycle.
   assign frame_start = (hcount == '0) && (vcount == V_LAST);
   assign in_active   = (hcount < H_ACT) && (vcount < V_ACT);
   assign occupancy   = count + CNT_W'(inflight);
   assign push        = inflight && !frame_start;
   assign pop         = in_active && !frame_start;
   assign pop_ok      = pop && (count != '0);

   // Fetch state register: idle until a frame start, idle again after the last pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= F_IDLE;
      else        state <= state_nxt;
   end

   // Next fetch state.
   always_comb begin
      state_nxt = state;
      if (frame_start)                                 state_nxt = F_RUN;
      else if (fetch_go && (fetch_addr == LAST_ADDR))  state_nxt = F_IDLE;
   end

   // Issue a display read whenever running and the FIFO plus the read in flight leave room.
   always_comb begin
      fetch_go = (state == F_RUN) && !frame_start && (occupancy < DEPTH_C);
   end

   // Ready stays low for the first clock after reset so nothing is granted while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) port_live <= 1'b0;
      else        port_live <= 1'b1;
   end

   assign wr_ready     = port_live && !fetch_go;
   assign cpu.wr_ready = wr_ready;
   assign wr_fire      = cpu.wr_valid && wr_ready;
   assign wr_in_range  = {1'b0, cpu.wr_addr} < PIX_TOTAL;

   // RAM port mux: display read wins, otherwise a granted CPU write (dropped if out of range).
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (fetch_go) begin
         mem_addr = fetch_addr;
      end else if (wr_fire) begin
         mem_addr  = cpu.wr_addr;
         mem_we    = wr_in_range;
         mem_wdata = cpu.wr_data;
      end
   end

   // Fetch address and read-in-flight tracking; a frame start discards any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_addr <= '0;
         inflight   <= 1'b0;
      end else begin
         inflight <= fetch_go;
         if (frame_start)   fetch_addr <= '0;
         else if (fetch_go) fetch_addr <= fetch_addr + ADDR_W'(1);
      end
   end

   // FIFO pointers and occupancy; frame start flushes ahead of any push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (frame_start) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop_ok)      count <= count + CNT_W'(1);
         else if (!push && pop_ok) count <= count - CNT_W'(1);
      end
   end

   // FIFO storage: read data lands one cycle after its address was issued.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rdata;
   end

   // Output stage: one pixel per active cycle, black in blanking or on an empty FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_p1    <= '0;
         underflow <= 1'b0;
      end else begin
         pix_p1 <= pop_ok ? fifo_mem[rd_ptr] : 24'd0;
         if (pop && (count == '0)) underflow <= 1'b1;
      end
   end

   assign final_pixel_r = pix_p1[23:16];
   assign final_pixel_g = pix_p1[15:8];
   assign final_pixel_b = pix_p1[7:0];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter on a reduced 16x8 raster (24 clocks per line,
// 12 lines per frame). Expected pixels are queued when the timing position is
// driven and compared by a separate monitor when the registered pixel appears.
`timescale 1ns/1ps

module tb_vga_fb_arbiter;
   localparam int H_ACTIVE   = 16;
   localparam int V_ACTIVE   = 8;
   localparam int V_TOTAL    = 12;
   localparam int H_TOTAL    = 24;
   localparam int ADDR_W     = 8;
   localparam int FIFO_DEPTH = 8;
   localparam int NPIX       = H_ACTIVE * V_ACTIVE;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [9:0]        hcount = '0;
   logic [9:0]        vcount = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [23:0]       mem_wdata;
   logic [23:0]       mem_rdata;
   logic [7:0]        fp_r, fp_g, fp_b;
   logic              underflow;

   vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) cpu_if ();

   vga_fb_arbiter #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
      .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
      .cpu(cpu_if),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .final_pixel_r(fp_r), .final_pixel_g(fp_g), .final_pixel_b(fp_b),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Single-port RAM, preloaded with a ramp (RAM[a] = a), one-cycle read latency.
   logic [23:0] ram [0:(1<<ADDR_W)-1];
   logic        loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 24'(i);
         loaded <= 1'b1;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int          due;
      int          h;
      int          v;
      logic [23:0] val;
   } exp_t;

   exp_t q[$];
   exp_t e_in, e_out;

   // Monitor: compare the registered pixel against the expectation due this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due < cyc) begin
         e_out = q.pop_front();
         checks++;
         errors++;
         $display("FAIL pixel_missed h=%0d v=%0d: no sample, expected 0x%0h", e_out.h, e_out.v, e_out.val);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         e_out = q.pop_front();
         check($sformatf("pixel h=%0d v=%0d", e_out.h, e_out.v), 32'({fp_r, fp_g, fp_b}), 32'(e_out.val));
      end
   end

   // Reference framebuffer contents as the bench intends them to be.
   logic [23:0] shadow [0:NPIX-1];
   int  h_s, v_s, ch, cv, nf;
   bit  sb_en, model_ok;
   logic [23:0] ev;

   // Drive one raster position, queue its expected pixel, advance the raster.
   task automatic tick();
      @(posedge clk); #1;
      hcount = 10'(h_s);
      vcount = 10'(v_s);
      if (h_s == 0 && v_s == V_TOTAL - 1) model_ok = 1'b1;
      if (h_s < H_ACTIVE && v_s < V_ACTIVE && model_ok) ev = shadow[v_s * H_ACTIVE + h_s];
      else                                              ev = 24'd0;
      if (sb_en) begin
         e_in.due = cyc + 1; e_in.h = h_s; e_in.v = v_s; e_in.val = ev;
         q.push_back(e_in);
      end
      if (h_s == H_TOTAL - 1) begin
         h_s = 0;
         v_s = (v_s == V_TOTAL - 1) ? 0 : v_s + 1;
      end else begin
         h_s = h_s + 1;
      end
   endtask

   task automatic run_to_frame_start();
      while (!(h_s == 0 && v_s == V_TOTAL - 1)) tick();
   endtask

   task automatic drain();
      sb_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NPIX; i++) shadow[i] = 24'(i);
      cpu_if.wr_valid = 1'b0;
      cpu_if.wr_addr  = '0;
      cpu_if.wr_data  = '0;
      sb_en = 1'b0;
      model_ok = 1'b0;

      // Reset held with random raster and CPU activity: everything quiet.
      repeat (4) begin
         @(posedge clk); #1;
         hcount          = 10'($urandom_range(0, 799));
         vcount          = 10'($urandom_range(0, 524));
         cpu_if.wr_valid = 1'($urandom_range(0, 1));
         cpu_if.wr_addr  = ADDR_W'($urandom);
         cpu_if.wr_data  = 24'($urandom);
         #1;
         check("rst_wr_ready", 32'(cpu_if.wr_ready), 32'd0);
         check("rst_mem_we", 32'(mem_we), 32'd0);
         check("rst_mem_addr", 32'(mem_addr), 32'd0);
         check("rst_pixel", 32'({fp_r, fp_g, fp_b}), 32'd0);
         check("rst_underflow", 32'(underflow), 32'd0);
      end
      cpu_if.wr_valid = 1'b0;

      // Release mid-frame at (5,3): no reads until frame start, active pops underflow.
      h_s = 5; v_s = 3; sb_en = 1'b1;
      tick();
      rst_n = 1'b1;
      nf = 0;
      while (!(h_s == 0 && v_s == V_TOTAL - 1)) begin
         tick(); #1;
         if (cpu_if.wr_ready !== 1'b1 || mem_addr !== '0) nf++;
      end
      check("no_fetch_before_frame", 32'(nf), 32'd0);
      check("underflow_after_midframe_release", 32'(underflow), 32'd1);

      // Restart cleanly in vertical blanking.
      drain();
      rst_n = 1'b0;
      #1;
      check("underflow_cleared_by_reset", 32'(underflow), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      h_s = 10; v_s = 9; model_ok = 1'b0; sb_en = 1'b1;
      run_to_frame_start();

      // Frame 1: plain ramp.
      repeat (H_TOTAL * V_TOTAL) tick();
      check("underflow_ramp_frame", 32'(underflow), 32'd0);

      // Frame 2: CPU hammering through line 2, then two writes in vertical blanking.
      repeat (H_TOTAL * V_TOTAL) begin
         ch = h_s; cv = v_s;
         cpu_if.wr_valid = (cv == 2);
         cpu_if.wr_addr  = ADDR_W'(ch);
         cpu_if.wr_data  = 24'(ch);
         if (cv == 9 && ch == 0) begin
            cpu_if.wr_valid = 1'b1; cpu_if.wr_addr = ADDR_W'(17); cpu_if.wr_data = 24'hFF0000;
            shadow[17] = 24'hFF0000;
         end
         if (cv == 9 && ch == 1) begin
            cpu_if.wr_valid = 1'b1; cpu_if.wr_addr = ADDR_W'(200); cpu_if.wr_data = 24'h123456;
         end
         tick(); #1;
         if (cv == 2 && ch >= 1 && ch < H_ACTIVE)
            check($sformatf("starved_wr_ready h=%0d", ch), 32'(cpu_if.wr_ready), 32'd0);
         if (cv == 2 && ch >= 18) begin
            check($sformatf("blank_wr_ready h=%0d", ch), 32'(cpu_if.wr_ready), 32'd1);
            check($sformatf("blank_mem_we h=%0d", ch), 32'(mem_we), 32'd1);
            check($sformatf("blank_mem_addr h=%0d", ch), 32'(mem_addr), 32'(ch));
         end
         if (cv == 9 && ch == 0) begin
            check("vblank_wr_ready", 32'(cpu_if.wr_ready), 32'd1);
            check("vblank_mem_we", 32'(mem_we), 32'd1);
            check("vblank_mem_addr", 32'(mem_addr), 32'd17);
            check("vblank_mem_wdata", 32'(mem_wdata), 32'hFF0000);
         end
         if (cv == 9 && ch == 1) begin
            check("oor_wr_ready", 32'(cpu_if.wr_ready), 32'd1);
            check("oor_mem_we", 32'(mem_we), 32'd0);
         end
      end
      cpu_if.wr_valid = 1'b0;

      // Frame 3: pixel (1,1) now red.
      repeat (H_TOTAL * V_TOTAL) tick();
      check("underflow_frame3", 32'(underflow), 32'd0);

      // Underflow: jump straight to (0,0) after reset, no frame start.
      drain();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      h_s = 0; v_s = 0; model_ok = 1'b0; sb_en = 1'b1;
      tick();
      tick(); #1;
      check("underflow_set", 32'(underflow), 32'd1);
      run_to_frame_start();
      repeat (H_TOTAL * V_TOTAL) tick();
      check("underflow_sticky", 32'(underflow), 32'd1);
      drain();
      rst_n = 1'b0;
      #1;
      check("underflow_reset_clear", 32'(underflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
